// File: rtl/dom_result_reader_pkg.sv
// Shared definitions for the output-memory result reader: FSM encoding,
// default geometry and a small sizing helper.
package dom_result_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RUNNING = 3'd2,
        ST_READ    = 3'd3,
        ST_DRAIN   = 3'd4
    } rdr_state_e;

    localparam int NUM_WORDS_DEF = 8;
    localparam int ADDR_W_DEF    = 3;
    localparam int DATA_W_DEF    = 16;

    // Bits needed to hold an occupancy count of 0..depth inclusive.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dom_result_reader_result_fifo.sv
// Small synchronous FIFO that buffers captured result words ahead of the
// host stream. A push into a full FIFO is accepted only when the same edge
// pops, so occupancy never exceeds DEPTH.
module result_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers; storage is cleared too so the head reads 0 out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/dom_result_reader.sv
// Result reader: arms on go, waits for the convolution engine's finish
// flag to fall and rise again, then reads every result word out of output
// memory and streams it to the host through a small FIFO.
module dom_result_reader
    import dom_result_reader_pkg::*;
#(
    parameter int NUM_WORDS  = NUM_WORDS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              xxx__dut__go,
    input  logic              dut__xxx__finish,
    output logic [ADDR_W-1:0] rdr__dom__address,
    output logic              rdr__dom__enable,
    output logic              rdr__dom__write,
    input  logic [DATA_W-1:0] dom__rdr__data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              rdr__xxx__done,
    output logic              busy
);

    localparam int CNT_W   = fifo_cnt_w(FIFO_DEPTH);
    localparam int ENTRY_W = DATA_W + ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    rdr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_en_q, rd_en_d;
    logic              write_q, write_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic [ENTRY_W-1:0] fifo_din, fifo_dout;
    logic [CNT_W:0]     occupied, capacity;
    logic               has_credit, drain_done;

    // The read issued on the previous edge lands in the FIFO on this edge,
    // together with its address and last marker.
    assign fifo_din  = {dom__rdr__data, rd_addr_q, (rd_addr_q == LAST_ADDR)};
    assign fifo_pop  = out_valid & out_ready;
    assign out_valid = ~fifo_empty;
    assign {out_data, out_index, out_last} = fifo_dout;

    result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rd_en_q),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Credit: a new read may issue only if a slot is guaranteed when its data
    // lands. A pop on this edge frees a slot, which keeps one word per cycle.
    always_comb begin
        occupied   = {1'b0, fifo_count} + (CNT_W + 1)'(rd_en_q);
        capacity   = (CNT_W + 1)'(FIFO_DEPTH) + (CNT_W + 1)'(fifo_pop);
        has_credit = (occupied < capacity);
        drain_done = !rd_en_q &&
                     ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && fifo_pop));
    end

    // Sequencing: arm, skip the stale finish, wait for finish, read, drain.
    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        rd_addr_d   = rd_addr_q;
        rd_en_d     = 1'b0;
        write_d     = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xxx__dut__go) begin
                    state_d     = ST_ARMED;
                    next_addr_d = '0;
                end
            end
            ST_ARMED: begin
                if (!dut__xxx__finish) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (dut__xxx__finish) state_d = ST_READ;
            end
            ST_READ: begin
                if (has_credit) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = next_addr_q;
                    if (next_addr_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end else begin
                        next_addr_d = next_addr_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // FSM and registered outputs; reset aborts any run without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            next_addr_q <= '0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            write_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            write_q     <= write_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    // A capture must never land on a full FIFO unless the same edge pops.
    assert property (@(posedge clk) disable iff (reset)
                     !(rd_en_q && fifo_full && !fifo_pop));

    assign rdr__dom__address = rd_addr_q;
    assign rdr__dom__enable  = rd_en_q;
    assign rdr__dom__write   = write_q;
    assign rdr__xxx__done    = done_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_dom_result_reader.sv
// Directed bench for dom_result_reader: table-driven stream runs plus
// hand-written sequences for stale finish, mid-read reset and go in DRAIN.
module tb_dom_result_reader;

    localparam int NW         = 8;
    localparam int FIFO_DEPTH = 2;
    localparam int DONE_LAT   = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic        finish;
    logic [2:0]  rdr__dom__address;
    logic        rdr__dom__enable;
    logic        rdr__dom__write;
    logic [15:0] dom_data = 16'h0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_index;
    logic        out_last;
    logic        done;
    logic        busy;

    dom_result_reader #(
        .NUM_WORDS (NW),
        .ADDR_W    (3),
        .DATA_W    (16),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .xxx__dut__go     (go),
        .dut__xxx__finish (finish),
        .rdr__dom__address(rdr__dom__address),
        .rdr__dom__enable (rdr__dom__enable),
        .rdr__dom__write  (rdr__dom__write),
        .dom__rdr__data   (dom_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_index        (out_index),
        .out_last         (out_last),
        .rdr__xxx__done   (done),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output memory model: data for the address registered at edge E is
    // presented before edge E+1.
    logic [15:0] mem [NW];
    always @(negedge clk) begin
        if (rdr__dom__enable) dom_data <= mem[rdr__dom__address];
    end

    typedef struct {
        logic [15:0] off;
        logic [2:0]  idx;
        logic        last;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] base;
        int          mode;
        bit          chk_lat;
    } run_t;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  idx;
        logic        last;
        int          cyc;
    } hs_t;

    vec_t exp_tab [NW];
    run_t runs [3];
    hs_t  hs_q [$];

    int n_cmp = 0;
    int n_fail = 0;
    int reads_issued = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int rdy_mode = 0;
    int stall_left = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Stream monitor and scoreboard, sampled mid-cycle.
    int          m_cnt = 0;
    bit          prev_en = 0, prev_hs = 0, prev_valid = 0, prev_ready = 0;
    logic [15:0] prev_data = 16'h0;
    logic [2:0]  prev_idx = 3'h0;
    logic        prev_last = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            m_cnt = 0; prev_en = 0; prev_hs = 0; prev_valid = 0; prev_ready = 0;
        end else begin
            if (rdr__dom__enable) begin
                check("credit_at_issue",
                      32'(m_cnt + int'(prev_en) < FIFO_DEPTH + int'(prev_hs)), 32'd1);
                check("write_low", 32'(rdr__dom__write), 32'd0);
                reads_issued++;
            end
            m_cnt = m_cnt + int'(prev_en) - int'(prev_hs);
            if (prev_en) check("fifo_overflow", 32'(m_cnt <= FIFO_DEPTH), 32'd1);
            check("valid_vs_fill", 32'(out_valid), 32'(m_cnt != 0));
            if (prev_valid && !prev_ready) begin
                check("stall_data", 32'(out_data), 32'(prev_data));
                check("stall_index", 32'(out_index), 32'(prev_idx));
                check("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) hs_q.push_back('{out_data, out_index, out_last, cyc});
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_en    = rdr__dom__enable;
            prev_hs    = out_valid && out_ready;
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            prev_idx   = out_index;
            prev_last  = out_last;
        end
    end

    // Sink behaviour: always ready, stall 10 valid cycles, or toggle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: begin
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        if (out_valid) stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = ~out_ready;
            endcase
        end
    end

    task automatic load_mem(input logic [15:0] base);
        for (int i = 0; i < NW; i++) mem[i] = base + 16'(i);
    endtask

    task automatic clear_stats();
        hs_q.delete();
        reads_issued = 0;
        done_cnt = 0;
        done_cyc = 0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_index"}, 32'(out_index), 32'd0);
        check({tag, "_last"}, 32'(out_last), 32'd0);
        check({tag, "_enable"}, 32'(rdr__dom__enable), 32'd0);
        check({tag, "_address"}, 32'(rdr__dom__address), 32'd0);
        check({tag, "_write"}, 32'(rdr__dom__write), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Optional go pulse, then finish 0 for one edge and 1; t is the edge
    // that samples finish high.
    task automatic start_run(input bit with_go, output int t);
        if (with_go) begin
            @(posedge clk); #1 go = 1'b1;
            @(posedge clk); #1 go = 1'b0;
        end
        finish = 1'b0;
        @(posedge clk); #1 finish = 1'b1;
        @(posedge clk); #1;
        t = cyc;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_words(input logic [15:0] base, input int t, input bit chk_lat,
                               input string tag);
        check({tag, "_count"}, 32'(hs_q.size()), 32'(NW));
        for (int i = 0; i < NW && i < hs_q.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), 32'(hs_q[i].data), 32'(base + exp_tab[i].off));
            check($sformatf("%s_index%0d", tag, i), 32'(hs_q[i].idx), 32'(exp_tab[i].idx));
            check($sformatf("%s_last%0d", tag, i), 32'(hs_q[i].last), 32'(exp_tab[i].last));
            if (chk_lat)
                check($sformatf("%s_cycle%0d", tag, i), 32'(hs_q[i].cyc), 32'(t + exp_tab[i].lat));
        end
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        if (chk_lat) check({tag, "_done_cycle"}, 32'(done_cyc), 32'(t + DONE_LAT));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int t;
        int n;
        int sz;

        exp_tab[0] = '{16'h0000, 3'd0, 1'b0, 2};
        exp_tab[1] = '{16'h0001, 3'd1, 1'b0, 3};
        exp_tab[2] = '{16'h0002, 3'd2, 1'b0, 4};
        exp_tab[3] = '{16'h0003, 3'd3, 1'b0, 5};
        exp_tab[4] = '{16'h0004, 3'd4, 1'b0, 6};
        exp_tab[5] = '{16'h0005, 3'd5, 1'b0, 7};
        exp_tab[6] = '{16'h0006, 3'd6, 1'b0, 8};
        exp_tab[7] = '{16'h0007, 3'd7, 1'b1, 9};

        runs[0] = '{16'h1000, 0, 1'b1};
        runs[1] = '{16'h1100, 1, 1'b0};
        runs[2] = '{16'h1200, 2, 1'b0};

        go = 1'b0;
        finish = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        reset = 1'b0;

        // Table-driven stream runs under three sink behaviours.
        for (int r = 0; r < 3; r++) begin
            load_mem(runs[r].base);
            clear_stats();
            rdy_mode = runs[r].mode;
            stall_left = (runs[r].mode == 1) ? 10 : 0;
            start_run(1'b1, t);
            if (runs[r].mode == 1) begin
                repeat (7) @(posedge clk);
                #2;
                check("stall_reads", 32'(reads_issued <= 2), 32'd1);
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_head", 32'(out_data), 32'(runs[r].base));
            end
            wait_done($sformatf("run%0d", r));
            check_words(runs[r].base, t, runs[r].chk_lat, $sformatf("run%0d", r));
        end
        rdy_mode = 0;

        // go while finish stays high: block waits in ARMED.
        load_mem(16'h1500);
        clear_stats();
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("armed_busy", 32'(busy), 32'd1);
        check("armed_reads", 32'(reads_issued), 32'd0);
        check("armed_valid", 32'(out_valid), 32'd0);
        start_run(1'b0, t);
        wait_done("armed");
        check_words(16'h1500, t, 1'b1, "armed");

        // Asynchronous reset after three words have streamed.
        load_mem(16'h1300);
        clear_stats();
        start_run(1'b1, t);
        n = 0;
        while (hs_q.size() < 3 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check("rst_three_words", 32'(hs_q.size() >= 3), 32'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk_outputs_zero("rst_mid");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        sz = hs_q.size();
        repeat (15) @(posedge clk);
        #1;
        check("rst_no_done", 32'(done_cnt), 32'd0);
        check("rst_idle", 32'(busy), 32'd0);
        check("rst_no_more_words", 32'(hs_q.size()), 32'(sz));
        load_mem(16'h1400);
        clear_stats();
        start_run(1'b1, t);
        wait_done("restart");
        check_words(16'h1400, t, 1'b1, "restart");

        // Second go while draining is ignored.
        load_mem(16'h1600);
        clear_stats();
        start_run(1'b1, t);
        n = 0;
        while (reads_issued < NW && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        wait_done("drain");
        repeat (6) @(posedge clk);
        #1;
        check("drain_reads", 32'(reads_issued), 32'(NW));
        check_words(16'h1600, t, 1'b1, "drain");
        load_mem(16'h1700);
        clear_stats();
        start_run(1'b1, t);
        wait_done("fresh");
        check_words(16'h1700, t, 1'b1, "fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
